// File: rtl/bist_ora_misr_pkg.sv
// Shared BIST definitions: ORA FSM encoding, MISR polynomial, default seed/golden values
// and the TPG LFSR seed the golden signature was derived from.
package bist_ora_misr_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCompact = 2'd1,
      StCompare = 2'd2,
      StDone    = 2'd3
   } ora_state_e;

   // x^3 + x + 1: feedback enters bits 0 and 1
   localparam logic [2:0] MisrTaps      = 3'b011;
   localparam logic [2:0] DefaultSeed   = 3'b000;
   localparam logic [2:0] DefaultGolden = 3'b111;
   localparam logic [2:0] LfsrSeed      = 3'b001;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: pure datapath, compacts a 2-bit response per enabled cycle.
module bist_misr
   import bist_ora_misr_pkg::*;
#(
   parameter int unsigned       SIG_W = 3,
   parameter logic [SIG_W-1:0]  SEED  = DefaultSeed,
   parameter logic [SIG_W-1:0]  TAPS  = MisrTaps
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [1:0]       din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q, sig_d, feed;
   logic             fb;

   always_comb begin
      fb        = sig_q[SIG_W-1];
      feed      = '0;
      feed[1:0] = din;
      sig_d     = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? TAPS : '0) ^ feed;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sig_q <= SEED;
      end else if (clear) begin
         sig_q <= SEED;
      end else if (enable) begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/bist_ora_misr.sv
// BIST output response analyser: compacts CUT responses into a MISR signature and compares
// the final signature against the golden value.
module bist_ora_misr
   import bist_ora_misr_pkg::*;
#(
   parameter int unsigned      SIG_W        = 3,
   parameter int unsigned      NUM_PATTERNS = 7,
   parameter logic [SIG_W-1:0] SEED         = DefaultSeed,
   parameter logic [SIG_W-1:0] GOLDEN_SIG   = DefaultGolden
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [1:0]       resp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int unsigned CntW = $clog2(NUM_PATTERNS + 1);

   ora_state_e      state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            misr_clear, misr_en;

   bist_misr #(
      .SIG_W (SIG_W),
      .SEED  (SEED),
      .TAPS  (MisrTaps)
   ) u_misr (
      .clock  (clock),
      .reset  (reset),
      .clear  (misr_clear),
      .enable (misr_en),
      .din    (resp),
      .sig    (signature)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      done_d     = done_q;
      pass_d     = pass_q;
      misr_clear = 1'b0;
      misr_en    = 1'b0;

      // start from any state begins a fresh run and drops any same-cycle sample
      if (start) begin
         state_d    = StCompact;
         count_d    = '0;
         done_d     = 1'b0;
         pass_d     = 1'b0;
         misr_clear = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: ;
            StCompact: begin
               if (resp_valid) begin
                  misr_en = 1'b1;
                  count_d = count_q + CntW'(1);
                  if (count_q == CntW'(NUM_PATTERNS - 1)) begin
                     state_d = StCompare;
                  end
               end
            end
            StCompare: begin
               pass_d  = (signature == GOLDEN_SIG);
               done_d  = 1'b1;
               state_d = StDone;
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         count_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign busy = (state_q == StCompact) || (state_q == StCompare);
   assign done = done_q;
   assign pass = pass_q;

endmodule
